// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2,
    REDIRECT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout.sv
// Memory wait counter: counts stalled fetch cycles and flags the last allowed one.
module fetch_timeout #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_c_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the stalled cycle that would bring the count to MAX_WAIT.
  assign expired_c_o = count_i && !clear_i && (cnt_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives pc load/increment, reads memory and
// holds each fetched word until decode accepts it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic [ADDR_W-1:0] pc_count_i,
  output logic              pc_load_o,
  output logic              pc_increment_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_accept_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              fetch_err_o
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic              instr_valid_q, instr_valid_d;
  logic              mem_req_q, mem_req_d;
  logic              pc_load_q, pc_load_d;
  logic              pc_increment_q, pc_increment_d;
  logic              fetch_err_q, fetch_err_d;
  logic              wait_clr, wait_cnt, wait_expired;

  assign wait_clr = (state_q != FETCH);
  assign wait_cnt = (state_q == FETCH) && !mem_ready_i;

  fetch_timeout #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (wait_clr),
    .count_i    (wait_cnt),
    .expired_c_o(wait_expired)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    instr_valid_d  = instr_valid_q;
    pc_target_d    = pc_target_q;
    fetch_err_d    = fetch_err_q;
    pc_load_d      = 1'b0;
    pc_increment_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ready_i) begin
          instr_d        = mem_rdata_i;
          instr_pc_d     = pc_count_i;
          instr_valid_d  = 1'b1;
          pc_increment_d = 1'b1;
          state_d        = HOLD;
        end else if (wait_expired) begin
          fetch_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      HOLD: begin
        if (instr_accept_i) begin
          instr_valid_d = 1'b0;
          if (branch_taken_i) begin
            pc_target_d = branch_target_i;
            pc_load_d   = 1'b1;
            state_d     = REDIRECT;
          end else begin
            state_d = enable_i ? FETCH : IDLE;
          end
        end
      end
      REDIRECT: begin
        state_d = enable_i ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      instr_q        <= '0;
      instr_pc_q     <= '0;
      pc_target_q    <= '0;
      instr_valid_q  <= 1'b0;
      mem_req_q      <= 1'b0;
      pc_load_q      <= 1'b0;
      pc_increment_q <= 1'b0;
      fetch_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      instr_pc_q     <= instr_pc_d;
      pc_target_q    <= pc_target_d;
      instr_valid_q  <= instr_valid_d;
      mem_req_q      <= mem_req_d;
      pc_load_q      <= pc_load_d;
      pc_increment_q <= pc_increment_d;
      fetch_err_q    <= fetch_err_d;
    end
  end

  assign pc_load_o      = pc_load_q;
  assign pc_increment_o = pc_increment_q;
  assign pc_target_o    = pc_target_q;
  assign mem_req_o      = mem_req_q;
  assign instr_o        = instr_q;
  assign instr_pc_o     = instr_pc_q;
  assign instr_valid_o  = instr_valid_q;
  assign fetch_err_o    = fetch_err_q;
  // The pc itself is the fetch address while a request is outstanding.
  assign mem_addr_o     = mem_req_q ? pc_count_i : '0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer that sits directly around the 16-bit program counter (pc).
- Drives the pc's load/increment controls and reads the pc count as the fetch address.
- Issues single-beat reads to instruction memory with a req/ready handshake and holds the fetched word for the decode stage until it is accepted.
- Handles taken-branch redirects and flags memory timeouts.

Parameters:
- ADDR_W, 16, width of pc count / memory address.
- DATA_W, 16, instruction word width.
- MAX_WAIT, 15, cycles FETCH may wait for mem_ready before timeout (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits new fetches.
- pc_count  input  ADDR_W  current pc value.
- pc_load  output  1  one-cycle pulse; pc loads pc_target.
- pc_increment  output  1  one-cycle pulse; pc advances by 1.
- pc_target  output  ADDR_W  redirect address presented with pc_load.
- mem_req  output  1  read request.
- mem_addr  output  ADDR_W  read address.
- mem_rdata  input  DATA_W  read data, valid with mem_ready.
- mem_ready  input  1  read complete.
- instr  output  DATA_W  fetched instruction.
- instr_pc  output  ADDR_W  address instr was fetched from.
- instr_valid  output  1  instr holds an unconsumed word.
- instr_accept  input  1  decode consumes instr (meaningful only while instr_valid=1).
- branch_taken  input  1  sampled with instr_accept; redirect requested.
- branch_target  input  ADDR_W  redirect address.
- fetch_err  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - All outputs 0: instr, instr_pc, pc_target, mem_addr, instr_valid, mem_req, pc_load, pc_increment, fetch_err.
  - Wait counter 0.
- States IDLE, FETCH, HOLD, REDIRECT. All outputs are registered except mem_addr, which equals pc_count while mem_req=1 and 0 otherwise.
- IDLE:
  - enable=1 -> FETCH next cycle.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_req=1, wait counter clears on entry.
  - mem_ready=1 -> capture mem_rdata into instr and pc_count into instr_pc; instr_valid=1; go to HOLD. pc_increment is high for exactly the first HOLD cycle.
  - No mem_ready -> counter increments. When the counter reaches MAX_WAIT without ready: fetch_err=1 (cleared only by reset), mem_req drops, go to IDLE.
  - Latency: ready observed in the first FETCH cycle -> instr_valid on the next edge.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable.
  - instr_accept=1, branch_taken=0: instr_valid clears; go to FETCH if enable=1, else IDLE.
  - instr_accept=1, branch_taken=1: instr_valid clears; pc_target=branch_target; go to REDIRECT.
- REDIRECT:
  - pc_load=1 for exactly one cycle, then FETCH if enable=1, else IDLE.
  - The pc value after REDIRECT is branch_target, even if pc_increment fired in the preceding cycle.
- pc_load and pc_increment are never high in the same cycle.
- A FETCH entered from HOLD sees the already-updated pc_count, because the increment pulse occupies at least one HOLD cycle before accept takes effect.
- enable deasserted mid-FETCH: the outstanding read completes normally (no abort); the unit returns to IDLE after accept.
- mem_rdata is ignored outside FETCH. instr_accept and branch_taken are ignored outside HOLD.
- Reset mid-FETCH: mem_req drops immediately (asynchronous); any in-flight data is discarded.
- Wait counter width is clog2(MAX_WAIT+1). pc wrap-around 0xFFFF->0x0000 is the pc's concern; fetch_unit passes addresses through unchanged.

Decomposition:
- Shared package fetch_pkg:
  - State encoding localparams: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2, REDIRECT=2'd3.
  - Default widths ADDR_W/DATA_W.
- Optional sub-module fetch_timeout: the wait counter with clear/enable/expired outputs.
- Everything else stays in one module.

Test Plan:
- Reset then enable=1, pc_count=0x0000, mem_ready after 2 cycles with rdata=0xA5A5 -> mem_req high 3 cycles, mem_addr=0x0000; instr=0xA5A5, instr_pc=0x0000, instr_valid=1; one pc_increment pulse.
- Sequential run: accept each word immediately, pc 0x0000..0x0003, memory returns addr^0xFFFF -> instr sequence 0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC; exactly 4 increments, 0 loads.
- Accept with branch_taken=1, branch_target=0x1234 -> one pc_load pulse with pc_target=0x1234; next mem_addr=0x1234; never pc_load and pc_increment together.
- Decode stall: instr_accept low 5 cycles -> instr_valid stays 1, instr unchanged, mem_req 0 throughout.
- Timeout: mem_ready never asserted, MAX_WAIT=15 -> fetch_err=1 after 15 FETCH cycles, mem_req=0, state IDLE; fetch_err persists until rst_n=0.
- Async reset asserted mid-FETCH between clock edges -> mem_req, instr_valid and fetch_err go 0 immediately; fetch resumes from pc_count after release.
